// File: rtl/cordic_hyp_pkg.sv
// Shared hyperbolic CORDIC constants: atanh(2^-i) table in Q.16,
// ln(2), repeat indices and the ln/exp FSM state encoding.
package cordic_hyp_pkg;

    // ln(2) at 16 fractional bits
    localparam logic signed [31:0] LN2 = 32'sd45426;

    // Iterations executed twice for hyperbolic convergence
    localparam int REP_A = 4;
    localparam int REP_B = 13;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        ITER,
        COMBINE,
        DONE
    } state_e;

    // atanh(2^-i) * 2^16, rounded; zero beyond table resolution
    function automatic logic [31:0] atanh_q16(input int i);
        logic [31:0] v;
        case (i)
            1:       v = 32'd35999;
            2:       v = 32'd16739;
            3:       v = 32'd8235;
            4:       v = 32'd4101;
            5:       v = 32'd2049;
            6:       v = 32'd1024;
            7:       v = 32'd512;
            8:       v = 32'd256;
            9:       v = 32'd128;
            10:      v = 32'd64;
            11:      v = 32'd32;
            12:      v = 32'd16;
            13:      v = 32'd8;
            14:      v = 32'd4;
            15:      v = 32'd2;
            16:      v = 32'd1;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/lead_one_enc.sv
// Combinational priority encoder: position of the highest set bit.
// Ports: val_i operand, pos_o bit index, zero_o set when val_i == 0.
module lead_one_enc #(
    parameter int M  = 24,
    parameter int PW = $clog2(M)
) (
    input  logic [M-1:0]  val_i,
    output logic [PW-1:0] pos_o,
    output logic          zero_o
);

    always_comb begin
        pos_o  = '0;
        zero_o = 1'b1;
        // Later (higher) bits overwrite, leaving the leading one
        for (int i = 0; i < M; i++) begin
            if (val_i[i]) begin
                pos_o  = PW'(i);
                zero_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ln.sv
// Natural log of an unsigned fixed-point operand by hyperbolic CORDIC.
// Ports: CLK, RST (sync, high), i_ce start, i_val operand,
// o_ln signed result, done result valid, error operand was zero.
module ln
    import cordic_hyp_pkg::*;
#(
    parameter int M          = 24,
    parameter int I_FRAC     = 8,
    parameter int W          = 24,
    parameter int WF         = 16,
    parameter int ITERATIONS = 16,
    parameter int O          = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_ce,
    input  logic [M-1:0] i_val,
    output logic [O-1:0] o_ln,
    output logic         done,
    output logic         error
);

    localparam int PW  = $clog2(M);
    localparam int IW  = $clog2(ITERATIONS + 1);
    localparam int RW  = W + 8;
    localparam int SH  = WF - I_FRAC;
    localparam int RND = 1 << (SH - 1);

    localparam logic signed [W-1:0]  ONE  = W'(1 << WF);
    localparam logic signed [RW-1:0] OMAX = RW'((1 << (O - 1)) - 1);
    localparam logic signed [RW-1:0] OMIN = ~OMAX;
    localparam logic [O-1:0]         ONEG = {1'b1, {(O - 1){1'b0}}};

    state_e              state_q, state_d;
    logic [M-1:0]        val_q, val_d;
    logic signed [7:0]   k_q, k_d;
    logic                zero_q, zero_d;
    logic signed [W-1:0] x_q, x_d;
    logic signed [W-1:0] y_q, y_d;
    logic signed [W-1:0] z_q, z_d;
    logic [IW-1:0]       i_q, i_d;
    logic                rep_q, rep_d;
    logic [O-1:0]        o_q, o_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // Normalisation
    logic [PW-1:0]       lo_pos;
    logic                lo_zero;
    logic [PW-1:0]       norm_sh;
    logic [M-1:0]        aligned;
    logic [M+WF-1:0]     wide;
    logic signed [W-1:0] mant;

    lead_one_enc #(
        .M (M),
        .PW(PW)
    ) u_enc (
        .val_i (val_q),
        .pos_o (lo_pos),
        .zero_o(lo_zero)
    );

    assign norm_sh = PW'(M - 1) - lo_pos;
    assign aligned = val_q << norm_sh;
    // Leading one sits at bit M-1; keep WF bits below it
    assign wide    = {aligned, {WF{1'b0}}} >> (M - 1);
    assign mant    = W'(wide);

    // Iteration datapath
    logic signed [W-1:0] xs, ys, ang;

    assign xs  = x_q >>> i_q;
    assign ys  = y_q >>> i_q;
    assign ang = W'(atanh_q16(int'(i_q)));

    // Combine: ln(x) = 2*z + k*ln2, rounded and saturated
    logic signed [RW-1:0] z_ext, k_ext, kl, r_sum, r_shr, r_sat;

    assign z_ext = RW'(z_q);
    assign k_ext = RW'(k_q);
    assign kl    = k_ext * RW'(LN2);
    assign r_sum = (z_ext <<< 1) + kl + RW'(RND);
    assign r_shr = r_sum >>> SH;
    assign r_sat = (r_shr > OMAX) ? OMAX :
                   (r_shr < OMIN) ? OMIN : r_shr;

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        k_d     = k_q;
        zero_d  = zero_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        rep_d   = rep_q;
        o_d     = o_q;
        done_d  = done_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (i_ce) begin
                    val_d   = i_val;
                    state_d = NORM;
                end
            end
            NORM: begin
                // Zero takes the COMBINE slot to report the error
                if (lo_zero) begin
                    zero_d  = 1'b1;
                    state_d = COMBINE;
                end else begin
                    zero_d  = 1'b0;
                    k_d     = 8'(lo_pos) - 8'(I_FRAC);
                    x_d     = mant + ONE;
                    y_d     = mant - ONE;
                    z_d     = '0;
                    i_d     = IW'(1);
                    rep_d   = 1'b0;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (y_q[W-1]) begin
                    x_d = x_q + ys;
                    y_d = y_q + xs;
                    z_d = z_q - ang;
                end else begin
                    x_d = x_q - ys;
                    y_d = y_q - xs;
                    z_d = z_q + ang;
                end
                if ((i_q == IW'(REP_A) || i_q == IW'(REP_B)) && !rep_q) begin
                    rep_d = 1'b1;
                end else begin
                    rep_d = 1'b0;
                    if (i_q == IW'(ITERATIONS)) begin
                        state_d = COMBINE;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end
            end
            COMBINE: begin
                done_d  = 1'b1;
                state_d = DONE;
                if (zero_q) begin
                    o_d   = ONEG;
                    err_d = 1'b1;
                end else begin
                    o_d   = r_sat[O-1:0];
                    err_d = 1'b0;
                end
            end
            DONE: begin
                if (!i_ce) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            val_q   <= '0;
            k_q     <= '0;
            zero_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            rep_q   <= 1'b0;
            o_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            k_q     <= k_d;
            zero_q  <= zero_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            rep_q   <= rep_d;
            o_q     <= o_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_ln  = o_q;
    assign done  = done_q;
    assign error = err_q;

endmodule

// File: tb/tb_ln.sv
// Directed testbench for ln: latency, accuracy, zero operand,
// reset abort, hold-after-done and operand changes mid-operation.
module tb_ln;

    logic        CLK;
    logic        RST;
    logic        i_ce;
    logic [23:0] i_val;
    logic [15:0] o_ln;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    ln dut (
        .CLK  (CLK),
        .RST  (RST),
        .i_ce (i_ce),
        .i_val(i_val),
        .o_ln (o_ln),
        .done (done),
        .error(error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got,
                         input int exp, input int tol);
        n_checks++;
        if (got > exp + tol || got < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d)",
                     tag, got, exp, tol);
        end
    endtask

    // Start an operation, wait for done, check result, hold i_ce
    // for 'hold' extra edges, then release and check done clears.
    task automatic run_op(input string tag, input logic [23:0] v,
                          input int exp_lat, input int exp_ln,
                          input int exp_err, input int chg_at,
                          input logic [23:0] alt, input int hold);
        int lat;
        bit got;
        @(negedge CLK);
        i_ce  = 1'b1;
        i_val = v;
        @(posedge CLK);
        lat = 0;
        got = 0;
        while (lat < 100 && !got) begin
            @(posedge CLK);
            #1;
            lat++;
            if (done) got = 1;
            if (lat == chg_at) i_val = alt;
        end
        check({tag, "_lat"}, lat, exp_lat, 0);
        check({tag, "_ln"}, int'($signed(o_ln)), exp_ln,
              exp_err ? 0 : 2);
        check({tag, "_err"}, int'(error), exp_err, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK);
            #1;
            check({tag, "_hold_done"}, int'(done), 1, 0);
            check({tag, "_hold_ln"}, int'($signed(o_ln)), exp_ln,
                  exp_err ? 0 : 2);
        end
        @(negedge CLK);
        i_ce = 1'b0;
        @(posedge CLK);
        #1;
        check({tag, "_clr"}, int'(done), 0, 0);
    endtask

    initial begin
        int cnt;
        RST   = 1'b1;
        i_ce  = 1'b0;
        i_val = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ln", int'(o_ln), 0, 0);
        check("rst_done", int'(done), 0, 0);
        check("rst_err", int'(error), 0, 0);
        @(negedge CLK);
        RST = 1'b0;

        run_op("one",   24'd256,     20,     0, 0, 0, 24'd0, 0);
        run_op("e",     24'd696,     20,   256, 0, 0, 24'd0, 0);
        run_op("half",  24'd128,     20,  -177, 0, 0, 24'd0, 0);
        run_op("x256",  24'd65536,   20,  1420, 0, 0, 24'd0, 0);
        run_op("max",   24'hFFFFFF,  20,  2839, 0, 0, 24'd0, 0);
        run_op("lsb",   24'd1,       20, -1420, 0, 0, 24'd0, 0);
        run_op("x1p5",  24'd384,     20,   104, 0, 0, 24'd0, 0);
        run_op("zero",  24'd0,        2, -32768, 1, 0, 24'd0, 0);
        run_op("after0", 24'd256,    20,     0, 0, 0, 24'd0, 0);
        // Operand change mid-ITER, i_ce held 5 edges past done
        run_op("hold",  24'd2560,    20,   589, 0, 5, 24'd1, 5);

        // Reset at edge 10 of an operation
        @(negedge CLK);
        i_ce  = 1'b1;
        i_val = 24'd2560;
        @(posedge CLK);
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        RST  = 1'b1;
        i_ce = 1'b0;
        @(posedge CLK);
        #1;
        check("abort_ln", int'(o_ln), 0, 0);
        check("abort_done", int'(done), 0, 0);
        check("abort_err", int'(error), 0, 0);
        @(negedge CLK);
        RST = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(posedge CLK);
            #1;
            if (done) cnt++;
        end
        check("abort_nodone", cnt, 0, 0);

        run_op("x2",    24'd512,     20,   177, 0, 0, 24'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
